// File: rtl/srio_rst_seq.sv
// srio_rst_seq: single-clock reset sequencer for the SRIO core.
// Holds all domain resets until clk_lock has been clean for HOLD_CYCLES,
// then releases buf_rst and the rst_out bits one by one, STAGE_GAP apart.
// It also runs the user link-reset handshake, with a timeout and a
// saturating count of link-reset events.
module srio_rst_seq #(
    parameter int NUM_RST        = 4,
    parameter int HOLD_CYCLES    = 4,
    parameter int STAGE_GAP      = 2,
    parameter int REINIT_TIMEOUT = 1024
) (
    input  logic               log_clk,
    input  logic               sys_rst,
    input  logic               clk_lock,
    input  logic               port_initialized,
    input  logic               phy_rcvd_link_reset,
    input  logic               force_reinit,
    output logic               controlled_force_reinit,
    output logic [NUM_RST-1:0] rst_out,
    output logic               buf_rst,
    output logic               rst_busy,
    output logic               reinit_timeout,
    output logic [7:0]         link_rst_cnt
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int SW = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;
    localparam int TW = (REINIT_TIMEOUT > 1) ? $clog2(REINIT_TIMEOUT) : 1;

    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(STAGE_GAP - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(NUM_RST - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(REINIT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_RELEASE   = 3'd1,
        ST_RUN       = 3'd2,
        ST_LINKRESET = 3'd3,
        ST_PHY_RESET = 3'd4
    } state_t;

    state_t        state_r, state_s;
    logic [HW-1:0] hold_cnt_r, hold_cnt_s;
    logic [GW-1:0] gap_cnt_r, gap_cnt_s;
    logic [SW-1:0] stage_r, stage_s;
    logic [TW-1:0] to_cnt_r, to_cnt_s;
    logic          phy_prev_r;

    logic [NUM_RST-1:0] rst_out_s;
    logic               buf_rst_s;
    logic               cfr_s;
    logic               timeout_s;
    logic               abort_s;
    logic               link_event_s;
    logic [7:0]         link_cnt_s;

    // Next-state and next-output computation; abort overrides every state.
    always_comb begin
        state_s      = state_r;
        hold_cnt_s   = hold_cnt_r;
        gap_cnt_s    = gap_cnt_r;
        stage_s      = stage_r;
        to_cnt_s     = to_cnt_r;
        rst_out_s    = rst_out;
        buf_rst_s    = buf_rst;
        cfr_s        = controlled_force_reinit;
        timeout_s    = 1'b0;
        abort_s      = ~clk_lock | phy_rcvd_link_reset;

        case (state_r)
            ST_HOLD: begin
                if (hold_cnt_r == HOLD_LAST) begin
                    state_s    = ST_RELEASE;
                    hold_cnt_s = '0;
                    buf_rst_s  = 1'b0;
                    gap_cnt_s  = '0;
                    stage_s    = '0;
                end else begin
                    hold_cnt_s = hold_cnt_r + HW'(1);
                end
            end
            ST_RELEASE: begin
                if (gap_cnt_r == GAP_LAST) begin
                    gap_cnt_s          = '0;
                    rst_out_s[stage_r] = 1'b0;
                    if (stage_r == STAGE_LAST) begin
                        state_s = ST_RUN;
                        stage_s = '0;
                    end else begin
                        stage_s = stage_r + SW'(1);
                    end
                end else begin
                    gap_cnt_s = gap_cnt_r + GW'(1);
                end
            end
            ST_RUN: begin
                if (force_reinit) begin
                    state_s  = ST_LINKRESET;
                    cfr_s    = 1'b1;
                    to_cnt_s = '0;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_LINKRESET: begin
                if (!port_initialized || (to_cnt_r == TO_LAST)) begin
                    state_s   = ST_PHY_RESET;
                    timeout_s = port_initialized;
                    to_cnt_s  = '0;
                    rst_out_s = {NUM_RST{1'b1}};
                    buf_rst_s = 1'b1;
                    cfr_s     = 1'b0;
                end else begin
                    to_cnt_s = to_cnt_r + TW'(1);
                end
            end
            ST_PHY_RESET: begin
                rst_out_s = {NUM_RST{1'b1}};
                buf_rst_s = 1'b1;
                cfr_s     = 1'b0;
                if (!force_reinit) begin
                    state_s    = ST_HOLD;
                    hold_cnt_s = '0;
                end else begin
                    state_s = ST_PHY_RESET;
                end
            end
            default: begin
                state_s    = ST_HOLD;
                hold_cnt_s = '0;
                gap_cnt_s  = '0;
                stage_s    = '0;
                to_cnt_s   = '0;
                rst_out_s  = {NUM_RST{1'b1}};
                buf_rst_s  = 1'b1;
                cfr_s      = 1'b0;
            end
        endcase

        if (abort_s) begin
            state_s    = ST_HOLD;
            hold_cnt_s = '0;
            gap_cnt_s  = '0;
            stage_s    = '0;
            to_cnt_s   = '0;
            rst_out_s  = {NUM_RST{1'b1}};
            buf_rst_s  = 1'b1;
            cfr_s      = 1'b0;
            timeout_s  = 1'b0;
        end else begin
            timeout_s = timeout_s;
        end

        // Entry to PHY_RESET and a fresh link-reset symbol burst in the
        // same cycle still count as one event.
        link_event_s = ((state_s == ST_PHY_RESET) && (state_r != ST_PHY_RESET)) |
                       (phy_rcvd_link_reset & ~phy_prev_r);
        if (link_event_s && (link_rst_cnt != 8'd255)) begin
            link_cnt_s = link_rst_cnt + 8'd1;
        end else begin
            link_cnt_s = link_rst_cnt;
        end
    end

    // State, counters and registered outputs, with synchronous reset.
    always_ff @(posedge log_clk) begin
        if (sys_rst) begin
            state_r                 <= ST_HOLD;
            hold_cnt_r              <= '0;
            gap_cnt_r               <= '0;
            stage_r                 <= '0;
            to_cnt_r                <= '0;
            phy_prev_r              <= 1'b0;
            rst_out                 <= {NUM_RST{1'b1}};
            buf_rst                 <= 1'b1;
            rst_busy                <= 1'b1;
            controlled_force_reinit <= 1'b0;
            reinit_timeout          <= 1'b0;
            link_rst_cnt            <= 8'd0;
        end else begin
            state_r                 <= state_s;
            hold_cnt_r              <= hold_cnt_s;
            gap_cnt_r               <= gap_cnt_s;
            stage_r                 <= stage_s;
            to_cnt_r                <= to_cnt_s;
            phy_prev_r              <= phy_rcvd_link_reset;
            rst_out                 <= rst_out_s;
            buf_rst                 <= buf_rst_s;
            rst_busy                <= (state_s != ST_RUN);
            controlled_force_reinit <= cfr_s;
            reinit_timeout          <= timeout_s;
            link_rst_cnt            <= link_cnt_s;
        end
    end

endmodule

// File: tb/tb_srio_rst_seq.sv
// Testbench for srio_rst_seq: directed scenarios followed by random
// stimulus, compared every cycle against a timeline-based reference model.
module tb_srio_rst_seq;

    localparam int N = 4;
    localparam int H = 4;
    localparam int G = 2;
    localparam int T = 16;

    logic         log_clk = 1'b0;
    logic         sys_rst;
    logic         clk_lock;
    logic         port_initialized;
    logic         phy_rcvd_link_reset;
    logic         force_reinit;
    logic         controlled_force_reinit;
    logic [N-1:0] rst_out;
    logic         buf_rst;
    logic         rst_busy;
    logic         reinit_timeout;
    logic [7:0]   link_rst_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: m_t counts clean edges since the last (re)start of
    // the release timeline; m_mode 0 = sequencing/run, 1 = link reset
    // handshake, 2 = PHY reset.
    int m_t    = 0;
    int m_mode = 0;
    int m_lk   = 0;
    bit m_to   = 1'b0;
    int m_cnt  = 0;
    bit m_prev = 1'b0;

    always #5 log_clk = ~log_clk;

    srio_rst_seq #(
        .NUM_RST        (N),
        .HOLD_CYCLES    (H),
        .STAGE_GAP      (G),
        .REINIT_TIMEOUT (T)
    ) dut (
        .log_clk                 (log_clk),
        .sys_rst                 (sys_rst),
        .clk_lock                (clk_lock),
        .port_initialized        (port_initialized),
        .phy_rcvd_link_reset     (phy_rcvd_link_reset),
        .force_reinit            (force_reinit),
        .controlled_force_reinit (controlled_force_reinit),
        .rst_out                 (rst_out),
        .buf_rst                 (buf_rst),
        .rst_busy                (rst_busy),
        .reinit_timeout          (reinit_timeout),
        .link_rst_cnt            (link_rst_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit rise;
        bit entry;
        if (sys_rst) begin
            m_t = 0; m_mode = 0; m_lk = 0; m_to = 1'b0; m_cnt = 0; m_prev = 1'b0;
            return;
        end
        rise   = phy_rcvd_link_reset && !m_prev;
        m_prev = phy_rcvd_link_reset;
        entry  = 1'b0;
        m_to   = 1'b0;
        if (!clk_lock || phy_rcvd_link_reset) begin
            m_mode = 0;
            m_t    = 0;
        end else if (m_mode == 0) begin
            if (m_t >= H + N * G) begin
                if (force_reinit) begin
                    m_mode = 1;
                    m_lk   = 0;
                end
            end else begin
                m_t++;
            end
        end else if (m_mode == 1) begin
            if (!port_initialized) begin
                m_mode = 2; entry = 1'b1;
            end else if (m_lk == T - 1) begin
                m_mode = 2; entry = 1'b1; m_to = 1'b1;
            end else begin
                m_lk++;
            end
        end else begin
            if (!force_reinit) begin
                m_mode = 0;
                m_t    = 0;
            end
        end
        if ((rise || entry) && m_cnt < 255) m_cnt++;
    endtask

    task automatic check_all();
        logic [N-1:0] e_rst;
        logic         e_buf;
        logic         e_busy;
        logic         e_cfr;
        if (m_mode == 0) begin
            for (int k = 0; k < N; k++) e_rst[k] = (m_t < H + (k + 1) * G);
            e_buf  = (m_t < H);
            e_busy = (m_t < H + N * G);
            e_cfr  = 1'b0;
        end else if (m_mode == 1) begin
            e_rst = '0; e_buf = 1'b0; e_busy = 1'b1; e_cfr = 1'b1;
        end else begin
            e_rst = '1; e_buf = 1'b1; e_busy = 1'b1; e_cfr = 1'b0;
        end
        check_eq("rst_out", rst_out, e_rst);
        check_eq("buf_rst", buf_rst, e_buf);
        check_eq("rst_busy", rst_busy, e_busy);
        check_eq("cfr", controlled_force_reinit, e_cfr);
        check_eq("timeout", reinit_timeout, m_to);
        check_eq("link_cnt", link_rst_cnt, m_cnt);
    endtask

    // One clock: drive inputs after the falling edge, model at the rising
    // edge, compare at the next falling edge.
    task automatic step(input logic s, input logic l, input logic p, input logic r, input logic f);
        sys_rst = s; clk_lock = l; port_initialized = p;
        phy_rcvd_link_reset = r; force_reinit = f;
        @(posedge log_clk);
        model_step();
        @(negedge log_clk);
        check_all();
    endtask

    initial begin
        logic s, l, p, r, f;
        sys_rst = 1'b1; clk_lock = 1'b0; port_initialized = 1'b1;
        phy_rcvd_link_reset = 1'b0; force_reinit = 1'b0;
        @(negedge log_clk);

        // Power-up with default timing
        repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("reset_rst", rst_out, 4'hF);
        repeat (20) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("pwr_busy", rst_busy, 1'b0);

        // Lock loss in the middle of the release
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (8) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("lockloss_rst", rst_out, 4'hF);
        repeat (16) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // User reinit, port_initialized drops 5 cycles later
        repeat (5) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("reinit_cnt", link_rst_cnt, 8'd1);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (16) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Timeout with port_initialized stuck high
        repeat (20) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        check_eq("timeout_cnt", link_rst_cnt, 8'd2);
        repeat (16) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Held link-reset counts once, then saturation
        repeat (10) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("held_cnt", link_rst_cnt, 8'd3);
        repeat (300) begin
            step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        check_eq("sat_cnt", link_rst_cnt, 8'd255);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("rst_cnt", link_rst_cnt, 8'd0);

        // sys_rst and link reset together while in LINKRESET
        repeat (16) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("simul_cnt", link_rst_cnt, 8'd0);
        check_eq("simul_cfr", controlled_force_reinit, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Random traffic
        f = 1'b0; p = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            s = ($urandom_range(0, 299) == 0);
            l = ($urandom_range(0, 79) != 0);
            r = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 19) == 0) f = ~f;
            if ($urandom_range(0, 29) == 0) p = ~p;
            step(s, l, p, r, f);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/srio_rst_seq.md
# srio_rst_seq

Parametrised, single-clock reset sequencer for the SRIO core. It replaces fixed 4-deep per-domain shift-register resets with a counted hold followed by staged, ordered release of `NUM_RST` reset outputs. It qualifies release with `clk_lock` and re-asserts on lock loss. It also owns the user link-reset handshake, adding a timeout and a saturating link-reset event counter.

## Interface
- `NUM_RST`, 4: number of sequenced reset outputs, ≥1.
- `HOLD_CYCLES`, 4: cycles of clean `clk_lock` with no trigger before release starts, ≥1.
- `STAGE_GAP`, 2: cycles between successive output releases, ≥1.
- `REINIT_TIMEOUT`, 1024: maximum cycles in LINKRESET waiting for `port_initialized` to drop, ≥1.

Ports:
- `log_clk` in 1: sole clock; all logic is on its rising edge.
- `sys_rst` in 1: synchronous, active-high reset. Highest priority.
- `clk_lock` in 1: MMCM lock.
- `port_initialized` in 1: port-initialized status.
- `phy_rcvd_link_reset` in 1: 4 consecutive reset symbols received.
- `force_reinit` in 1: user reinit request, level.
- `controlled_force_reinit` out 1: reinit request to PHY.
- `rst_out` out NUM_RST: per-domain resets; bit 0 is released first.
- `buf_rst` out 1: buffer reset; drops before `rst_out[0]`.
- `rst_busy` out 1: high whenever the state is not RUN.
- `reinit_timeout` out 1: one-cycle pulse when the LINKRESET timeout fires.
- `link_rst_cnt` out 8: saturating count of link-reset events.

## Operation
- All outputs are registered.
- Reset values (`sys_rst`=1):
  - state HOLD
  - `rst_out` = all ones
  - `buf_rst` = 1
  - `rst_busy` = 1
  - `controlled_force_reinit` = 0
  - `reinit_timeout` = 0
  - `link_rst_cnt` = 0
  - all internal counters = 0
- Priority: `sys_rst` > abort (`clk_lock`=0 or `phy_rcvd_link_reset`=1, any state) > normal transitions.
- Abort behaviour: next state is HOLD. `rst_out` is all ones, `buf_rst`=1, counters are cleared, `controlled_force_reinit`=0.
- States:
  - **HOLD**: `hold_cnt` increments each cycle. When `hold_cnt`==HOLD_CYCLES-1, go to RELEASE; `buf_rst` drops to 0 and `gap_cnt`=0.
  - **RELEASE**: `gap_cnt` increments. When `gap_cnt`==STAGE_GAP-1:
    - clear `rst_out[stage]`, increment `stage`, set `gap_cnt`=0;
    - on the edge that clears bit NUM_RST-1, go to RUN (`rst_busy`=0).
  - **RUN**: if `force_reinit`=1, go to LINKRESET with `controlled_force_reinit`=1 and `to_cnt`=0.
  - **LINKRESET**:
    - if `port_initialized`=0, go to PHY_RESET;
    - else if `to_cnt`==REINIT_TIMEOUT-1, go to PHY_RESET and pulse `reinit_timeout`;
    - else increment `to_cnt`.
    - `force_reinit` dropping has no effect here.
  - **PHY_RESET**: `rst_out` all ones, `buf_rst`=1, `controlled_force_reinit`=0. Stay at least one cycle; go to HOLD once `force_reinit`=0.
- `force_reinit` is ignored in HOLD and RELEASE.
- `link_rst_cnt` increments by 1, saturating at 255, on:
  - entry to PHY_RESET, or
  - a rising edge of `phy_rcvd_link_reset` (registered previous value).
  - If both occur in the same cycle, it increments by 1 only.
  - A held-high `phy_rcvd_link_reset` counts once.

## Timing
- Time is counted from edge 1, the first edge with `sys_rst`=0, `clk_lock`=1 and no trigger:
  - HOLD → RELEASE at edge HOLD_CYCLES; `buf_rst` low after that edge.
  - `rst_out[k]` falls after edge HOLD_CYCLES+(k+1)·STAGE_GAP.
  - `rst_busy` falls with `rst_out[NUM_RST-1]`.
- With defaults: `buf_rst` falls after edge 4; `rst_out[0..3]` fall after edges 6, 8, 10 and 12.
- `controlled_force_reinit` rises one edge after `force_reinit` is sampled high in RUN.
- With `port_initialized` held high, LINKRESET lasts exactly REINIT_TIMEOUT cycles.
- Abort takes effect on the same edge that samples it; release restarts from edge 1.
- An abort mid-RELEASE re-asserts already-released bits at once.

## Test plan
- **Power-up, defaults**: `sys_rst` high for 3 cycles, then low with `clk_lock`=1 → `buf_rst` falls after edge 4; `rst_out` goes 1110, 1100, 1000, 0000 after edges 6, 8, 10, 12; `rst_busy`=0 from edge 12.
- **Lock loss mid-release**: `clk_lock`=0 for 1 cycle at edge 9 → `rst_out`=1111 and `buf_rst`=1 next cycle; full sequence repeats, counted from the first lock-high edge.
- **User reinit**: in RUN, `force_reinit`=1, then `port_initialized` falls 5 cycles later → `controlled_force_reinit` high for 5 cycles, PHY_RESET entered, `link_rst_cnt`=1. Then `force_reinit` drops → HOLD and the release sequence.
- **Timeout**: REINIT_TIMEOUT=16, `port_initialized` stuck at 1 → `reinit_timeout` single pulse after the 16th LINKRESET cycle, PHY_RESET entered, `link_rst_cnt` increments.
- **Link-reset counting**: `phy_rcvd_link_reset` held high 10 cycles → count +1 only; 300 separate pulses → count saturates at 255; `sys_rst` → count 0.
- **Simultaneous events**: `sys_rst` and `phy_rcvd_link_reset` both high while in LINKRESET → full reset values, `link_rst_cnt`=0.
